// File: rtl/image_mem_pkg.sv
// Shared types and geometry for the image frame-memory arbiter.
// Frame is 320x240 pixels of 8 bits, one word per address.
package image_mem_pkg;
   localparam int IMG_W      = 320;
   localparam int IMG_H      = 240;
   localparam int MEM_DEPTH  = IMG_W * IMG_H;
   localparam int ADDR_WIDTH = 17;
   localparam int DATA_WIDTH = 8;

   localparam logic [DATA_WIDTH-1:0] CLEAR_VALUE = 8'h00;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WR,
      GNT_RD,
      GNT_CLR
   } grant_t;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } arb_state_t;

   function automatic logic addr_ok(addr_t a, int depth);
      return int'(a) < depth;
   endfunction
endpackage

// File: rtl/image_mem_arbiter_if.sv
// Client request/return, frame-memory port and clear control bundle.
// slave = arbiter side, master = clients plus memory side.
interface image_mem_arbiter_if;
   import image_mem_pkg::*;

   logic  wr_valid;
   logic  wr_ready;
   addr_t wr_addr;
   data_t wr_data;

   logic  rd_valid;
   logic  rd_ready;
   addr_t rd_addr;
   logic  rd_data_valid;
   data_t rd_data;
   logic  rd_err;

   logic  mem_wr_en;
   addr_t mem_addr;
   data_t mem_data_in;
   data_t mem_data_out;

   logic  clear_start;
   logic  clear_busy;

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      input  rd_valid, rd_addr,
      input  mem_data_out, clear_start,
      output wr_ready, rd_ready,
      output rd_data_valid, rd_data, rd_err,
      output mem_wr_en, mem_addr, mem_data_in,
      output clear_busy
   );

   modport master (
      output wr_valid, wr_addr, wr_data,
      output rd_valid, rd_addr,
      output mem_data_out, clear_start,
      input  wr_ready, rd_ready,
      input  rd_data_valid, rd_data, rd_err,
      input  mem_wr_en, mem_addr, mem_data_in,
      input  clear_busy
   );
endinterface

// File: rtl/img_clear_seq.sv
// Frame-clear address counter: walks 0..DEPTH-1 while enabled,
// flags the final word so the arbiter can leave the clear state.
module img_clear_seq
   import image_mem_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   output addr_t addr,
   output logic  done
);

   addr_t cnt_q;
   addr_t cnt_d;

   assign addr = cnt_q;
   assign done = en && (int'(cnt_q) == DEPTH - 1);

   always_comb begin
      cnt_d = cnt_q;
      if (!en || done) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + addr_t'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/image_mem_arbiter.sv
// Round-robin arbiter for one writer and one reader on a single-port frame memory.
// Optional frame clear is built only when IMAGE_MEM_CLEAR_EN is defined.
module image_mem_arbiter
   import image_mem_pkg::*;
#(
   parameter int    DEPTH = MEM_DEPTH,
   parameter data_t FILL  = CLEAR_VALUE
) (
   input  logic               clk,
   input  logic               rst,
   image_mem_arbiter_if.slave bus
);

   grant_t     grant;
   grant_t     last_grant_q;
   grant_t     last_grant_d;
   arb_state_t state_q;
   arb_state_t state_d;
   logic       rd_data_valid_q;
   logic       rd_data_valid_d;
   data_t      rd_data_q;
   data_t      rd_data_d;
   logic       rd_err_q;
   logic       rd_err_d;
   addr_t      clr_addr;
   logic       wr_in;
   logic       rd_in;

   assign wr_in = addr_ok(bus.wr_addr, DEPTH);
   assign rd_in = addr_ok(bus.rd_addr, DEPTH);

`ifdef IMAGE_MEM_CLEAR_EN
   logic clr_done;

   img_clear_seq #(
      .DEPTH (DEPTH)
   ) u_clear_seq (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == ST_CLEAR),
      .addr (clr_addr),
      .done (clr_done)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (bus.clear_start) state_d = ST_CLEAR;
         ST_CLEAR: if (clr_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end
`else
   logic unused_clear_start;

   assign unused_clear_start = bus.clear_start;
   assign clr_addr = '0;
   assign state_d  = ST_IDLE;
`endif

   // Tie goes to whichever client was not served last.
   always_comb begin
      grant = GNT_NONE;
      if (rst) begin
         grant = GNT_NONE;
      end else if (state_q == ST_CLEAR) begin
         grant = GNT_CLR;
      end else if (bus.wr_valid && bus.rd_valid) begin
         grant = (last_grant_q == GNT_WR) ? GNT_RD : GNT_WR;
      end else if (bus.wr_valid) begin
         grant = GNT_WR;
      end else if (bus.rd_valid) begin
         grant = GNT_RD;
      end
   end

   always_comb begin
      bus.wr_ready    = (grant == GNT_WR);
      bus.rd_ready    = (grant == GNT_RD);
      bus.clear_busy  = (state_q == ST_CLEAR);
      bus.mem_wr_en   = 1'b0;
      bus.mem_addr    = bus.rd_addr;
      bus.mem_data_in = bus.wr_data;
      unique case (grant)
         GNT_WR: begin
            bus.mem_addr  = bus.wr_addr;
            bus.mem_wr_en = wr_in;
         end
         GNT_CLR: begin
            bus.mem_addr    = clr_addr;
            bus.mem_data_in = FILL;
            bus.mem_wr_en   = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      last_grant_d    = last_grant_q;
      rd_data_valid_d = (grant == GNT_RD);
      rd_err_d        = 1'b0;
      rd_data_d       = rd_data_q;
      if (grant == GNT_WR || grant == GNT_RD) begin
         last_grant_d = grant;
      end
      if (grant == GNT_RD) begin
         rd_err_d  = !rd_in;
         rd_data_d = rd_in ? bus.mem_data_out : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         last_grant_q    <= GNT_WR;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= '0;
         rd_err_q        <= 1'b0;
      end else begin
         state_q         <= state_d;
         last_grant_q    <= last_grant_d;
         rd_data_valid_q <= rd_data_valid_d;
         rd_data_q       <= rd_data_d;
         rd_err_q        <= rd_err_d;
      end
   end

   assign bus.rd_data_valid = rd_data_valid_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.rd_err        = rd_err_q;

endmodule
